// File: rtl/perf_event_counter_bank.sv
// Bank of programmable performance counters plus a free-running cycle counter and a registered read port.
// Define PERF_SNAPSHOT_EN to add the snap input and shadow registers that reads then return.
module perf_event_counter_bank #(
  parameter  int unsigned NUM_EVENTS = 32,
  parameter  int unsigned NUM_CNT    = 8,
  parameter  int unsigned CNT_W      = 48,
  localparam int unsigned SEL_W      = $clog2(NUM_EVENTS),
  localparam int unsigned IDX_W      = $clog2(NUM_CNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic                  cfg_en,
  input  logic                  cfg_sat,
  input  logic                  freeze,
  input  logic                  clear,
`ifdef PERF_SNAPSHOT_EN
  input  logic                  snap,
`endif
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_vld,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  rd_err,
  output logic [NUM_CNT-1:0]    ovf,
  output logic                  cyc_ovf
);

  localparam int unsigned      EV_PAD_W = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Selects beyond NUM_EVENTS land on zero padding, so such counters never increment.
  logic [EV_PAD_W-1:0] ev_pad;

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [SEL_W-1:0]   sel_q [NUM_CNT];
  logic [SEL_W-1:0]   sel_d [NUM_CNT];
  logic [NUM_CNT-1:0] en_q, en_d, sat_q, sat_d, ovf_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               cyc_ovf_d;

  logic [CNT_W-1:0]   src_cnt [NUM_CNT];
  logic [CNT_W-1:0]   src_cyc;
  logic [CNT_W-1:0]   rd_val_c;
  logic               rd_oob_c;

  assign ev_pad = EV_PAD_W'(event_i);

  // Next-state: clear beats cfg_we zeroing, which beats increment.
  always_comb begin
    cyc_d     = cyc_q;
    cyc_ovf_d = cyc_ovf;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    en_d      = en_q;
    sat_d     = sat_q;
    ovf_d     = ovf;
    if (!freeze) begin
      cyc_d = cyc_q + CNT_W'(1);
      if (cyc_q == CNT_MAX) cyc_ovf_d = 1'b1;
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        sel_d[i] = cfg_sel;
        en_d[i]  = cfg_en;
        sat_d[i] = cfg_sat;
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en_q[i] && !freeze && ev_pad[sel_q[i]]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          if (!sat_q[i]) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
    end
    if (clear) begin
      cyc_d     = '0;
      cyc_ovf_d = 1'b0;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shd_q [NUM_CNT];
  logic [CNT_W-1:0] shd_cyc_q;

  // Shadows take post-update values and ignore clear.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_CNT; i++) shd_q[i] <= '0;
      shd_cyc_q <= '0;
    end else if (snap) begin
      shd_q     <= cnt_d;
      shd_cyc_q <= cyc_d;
    end
  end

  assign src_cnt = shd_q;
  assign src_cyc = shd_cyc_q;
`else
  assign src_cnt = cnt_q;
  assign src_cyc = cyc_q;
`endif

  // Read mux over pre-update values; out-of-range index yields zero.
  always_comb begin
    rd_val_c = '0;
    rd_oob_c = rd_idx > IDX_W'(NUM_CNT);
    if (rd_idx == IDX_W'(NUM_CNT)) rd_val_c = src_cyc;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val_c = src_cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      en_q    <= '0;
      sat_q   <= '0;
      ovf     <= '0;
      cyc_q   <= '0;
      cyc_ovf <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      sat_q   <= sat_d;
      ovf     <= ovf_d;
      cyc_q   <= cyc_d;
      cyc_ovf <= cyc_ovf_d;
      rd_vld  <= rd_req;
      rd_err  <= rd_req && rd_oob_c;
      rd_data <= rd_req ? rd_val_c : '0;
    end
  end

endmodule

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
- Parametrised bank of general-purpose performance counters for the 5-stage RISC-V core.
- Replaces the hard-wired per-event counter struct with NUM_CNT programmable counters. Each counter selects one of NUM_EVENTS single-cycle event strobes.
- Also provides a free-running cycle counter, a global freeze/clear, per-counter overflow flags and a registered read port for the testbench or the CSR path.
- Event producers (fetch/execute/branch logic) supply already de-duplicated one-cycle strobes, one per retired event.

Parameters:
NUM_EVENTS, 32, number of event strobe inputs
NUM_CNT, 8, number of programmable counters
CNT_W, 48, width of every counter including the cycle counter (legal 8..64)
SEL_W, $clog2(NUM_EVENTS), width of event-select field (derived, not overridden)
IDX_W, $clog2(NUM_CNT+1), width of counter index (derived)

Ports:
clk  input  1  core clock
rst_l  input  1  asynchronous active-low reset
event_i  input  NUM_EVENTS  event strobes; bit e high = one occurrence of event e this cycle
cfg_we  input  1  write configuration of counter cfg_idx
cfg_idx  input  IDX_W  counter being configured (0..NUM_CNT-1)
cfg_sel  input  SEL_W  event number the counter tracks
cfg_en  input  1  counter enable
cfg_sat  input  1  1 = saturate at all-ones, 0 = wrap to zero
freeze  input  1  level; while high no counter (including cycle) changes
clear  input  1  pulse; zero all counters and overflow flags
rd_req  input  1  read request
rd_idx  input  IDX_W  0..NUM_CNT-1 = programmable counter; NUM_CNT = cycle counter
rd_vld  output  1  read data valid
rd_data  output  CNT_W  read value
rd_err  output  1  index out of range, qualified by rd_vld
ovf  output  NUM_CNT  sticky overflow flag per programmable counter
cyc_ovf  output  1  sticky overflow flag for cycle counter

Behaviour:
- Reset (rst_l low, asynchronous): all counters 0; cycle counter 0; all sel/en/sat fields 0; ovf 0; cyc_ovf 0; rd_vld 0; rd_data 0; rd_err 0.
- Cycle counter: +1 every cycle unless freeze is high; always wraps. Wrap from all-ones to 0 sets cyc_ovf.
- Counter i increments at the clock edge when en[i]=1, freeze=0 and event_i[sel[i]]=1. Maximum increment is one per cycle.
- If sel[i] >= NUM_EVENTS (non-power-of-2 NUM_EVENTS only), the counter never increments.
- Overflow, wrap mode: all-ones +1 gives 0 and sets ovf[i].
- Overflow, saturate mode: value holds at all-ones. ovf[i] is set on the first attempted increment at all-ones.
- ovf and cyc_ovf are sticky until clear, reset, or (for ovf[i] only) cfg_we to counter i.
- cfg_we: at the edge, writes sel/en/sat of counter cfg_idx and zeroes that counter and ovf[cfg_idx]. An event in the same cycle is not counted. cfg_idx >= NUM_CNT is ignored.
- Priority per counter, highest first: clear > cfg_we zeroing > increment. clear in the same cycle as cfg_we: config is still written; all counters are zeroed.
- clear does not alter configuration. freeze does not block clear, cfg_we or reads.
- Read port: rd_req in cycle t gives rd_vld=1 in cycle t+1. rd_data is the value the selected counter held during cycle t, i.e. before that cycle's update.
- rd_vld is high for exactly one cycle per request; back-to-back requests are accepted every cycle.
- rd_idx > NUM_CNT: rd_data=0 and rd_err=1 in t+1. rd_err=0 whenever rd_vld=0.
- Width: all arithmetic is CNT_W bits unsigned; no carry beyond CNT_W.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Enabled: adds input snap (pulse) and a CNT_W shadow register per counter plus one for the cycle counter.
  - snap captures every live value, post-update of that cycle, at the edge.
  - Reads return shadow values, so a consistent set can be read over many cycles while counting continues.
  - Shadows reset to 0 and are not affected by clear.
  - snap and rd_req in the same cycle: the read returns the pre-snap shadow.
- Disabled: no snap port; reads return live values as described above.

Test Plan:
- Reset then 10 idle cycles; rd_req idx=NUM_CNT -> rd_data=10 next cycle. Counters 0..7 read 0 and ovf=0.
- Configure ctr 2 sel=5 en=1; pulse event_i[5] on 7 cycles, with event_i[4] on others -> ctr 2 reads 7 and all other counters read 0.
- CNT_W=8 build, ctr 0 wrap mode with event every cycle for 256 cycles -> reads 0, ovf[0]=1. Same with sat=1 -> reads 255, ovf[0]=1.
- freeze high for 20 cycles with events active -> all counters and cycle counter unchanged. Release -> counting resumes the next cycle.
- clear together with cfg_we for ctr 1 and event strobes -> every counter 0, ovf 0, ctr 1 config updated. rd_idx=NUM_CNT+1 -> rd_err=1, rd_data=0.
- PERF_SNAPSHOT_EN: snap at cycle count 100, read the cycle counter 30 cycles later -> 100. rst_l asserted mid-run -> all outputs and shadows 0 immediately, with no clock edge required.
